// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants and receiver state encoding for the PS/2 keyboard
// decoder and its scan-code lookup.
// ---------------------------------------------------------------------------
package ps2_pkg;

    // Set-2 prefix bytes and the blank display character.
    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// ---------------------------------------------------------------------------
// ps2_scan_to_ascii
// Combinational set-2 scan code to ASCII lookup for the characters the
// seven-segment driver can show.
//
// Ports:
//   i_scan   in   8  set-2 make code
//   o_hit    out  1  code is in the table
//   o_ascii  out  8  ASCII of the code (8'h00 when o_hit is 0)
// ---------------------------------------------------------------------------
module ps2_scan_to_ascii (
    input  logic [7:0] i_scan,
    output logic       o_hit,
    output logic [7:0] o_ascii
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_hit   = 1'b1;
        o_ascii = 8'h00;
        case (i_scan)
            8'h45:   o_ascii = "0";
            8'h16:   o_ascii = "1";
            8'h1E:   o_ascii = "2";
            8'h26:   o_ascii = "3";
            8'h25:   o_ascii = "4";
            8'h2E:   o_ascii = "5";
            8'h36:   o_ascii = "6";
            8'h3D:   o_ascii = "7";
            8'h3E:   o_ascii = "8";
            8'h46:   o_ascii = "9";
            8'h1C:   o_ascii = "A";
            8'h32:   o_ascii = "B";
            8'h21:   o_ascii = "C";
            8'h23:   o_ascii = "D";
            8'h24:   o_ascii = "E";
            8'h2B:   o_ascii = "F";
            8'h29:   o_ascii = " ";
            8'h4E:   o_ascii = "-";
            8'h2D:   o_ascii = "r";
            8'h3C:   o_ascii = "U";
            8'h4B:   o_ascii = "L";
            8'h44:   o_ascii = "o";
            8'h31:   o_ascii = "n";
            8'h1B:   o_ascii = "S";
            8'h4D:   o_ascii = "P";
            default: o_hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Receives PS/2 keyboard frames, checks framing/parity, and turns set-2
// make/break sequences into a held ASCII key for the seven-segment driver.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk fall mid-frame before abort
//   RELEASE_BLANK   1: releasing the displayed key blanks it to " "
//
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous active-low reset
//   ps2_clk     in   1  asynchronous PS/2 clock pin
//   ps2_data    in   1  asynchronous PS/2 data pin
//   key         out  8  ASCII of last accepted key, held
//   key_valid   out  1  one-cycle pulse when key is written
//   scan_code   out  8  last good raw byte (including F0/E0)
//   scan_valid  out  1  one-cycle pulse per good byte
//   frame_err   out  1  one-cycle pulse on bad start/parity/stop/timeout
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter bit RELEASE_BLANK  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int          TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    // Pin synchronizers; idle level of both pins is high.
    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;
    logic w_fall;

    rx_state_t     r_state, w_next_state;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;     // {stop, parity, d[7:0]} once the frame is in
    logic [TW-1:0] r_to_cnt;
    logic          r_break_pending;
    logic          r_ext_pending;

    logic          w_frame_good;
    logic          w_frame_bad;
    logic          w_hit;
    logic [7:0]    w_ascii;

    assign w_fall = r_clk_prev & ~r_clk_sync;

    ps2_scan_to_ascii u_lookup (
        .i_scan  (r_shift[7:0]),
        .o_hit   (w_hit),
        .o_ascii (w_ascii)
    );

    // -----------------------------------------------------------------------
    // Receiver FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Receiver FSM: next state and frame verdict
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    if (!r_dat_sync) w_next_state = ST_SHIFT;
                    else             w_frame_bad  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    if (r_bit_cnt == LAST_BIT) w_next_state = ST_CHECK;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next_state = ST_IDLE;
                    w_frame_bad  = 1'b1;
                end
            end
            ST_CHECK: begin
                w_next_state = ST_IDLE;
                // XOR over data and parity is 1 for correct odd parity.
                if (r_shift[9] && (^r_shift[8:0])) w_frame_good = 1'b1;
                else                               w_frame_bad  = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Synchronizers, shift datapath, decode and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_meta      <= 1'b1;
            r_clk_sync      <= 1'b1;
            r_clk_prev      <= 1'b1;
            r_dat_meta      <= 1'b1;
            r_dat_sync      <= 1'b1;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_to_cnt        <= '0;
            r_break_pending <= 1'b0;
            r_ext_pending   <= 1'b0;
            key             <= ASCII_SPACE;
            key_valid       <= 1'b0;
            scan_code       <= 8'h00;
            scan_valid      <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;

            frame_err  <= w_frame_bad;
            scan_valid <= w_frame_good;
            key_valid  <= 1'b0;

            if (r_state == ST_SHIFT) begin
                if (w_fall) begin
                    r_shift   <= {r_dat_sync, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt  <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
                if (r_state == ST_IDLE && w_fall && !r_dat_sync) begin
                    r_bit_cnt <= 4'd1;
                end
            end

            // Decode lands in the same edge as scan_code, so key_valid and
            // scan_valid rise together two cycles after the stop-bit strobe.
            if (w_frame_good) begin
                scan_code <= r_shift[7:0];
                if (r_shift[7:0] == PS2_BREAK) begin
                    r_break_pending <= 1'b1;
                end else if (r_shift[7:0] == PS2_EXT) begin
                    r_ext_pending <= 1'b1;
                end else if (r_break_pending) begin
                    r_break_pending <= 1'b0;
                    r_ext_pending   <= 1'b0;
                    if (RELEASE_BLANK && w_hit && (w_ascii == key)) begin
                        key       <= ASCII_SPACE;
                        key_valid <= 1'b1;
                    end
                end else if (r_ext_pending) begin
                    // Extended keys have no display character.
                    r_ext_pending <= 1'b0;
                end else if (w_hit) begin
                    key       <= w_ascii;
                    key_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder. Two instances share the pins: dut0
// keeps the key on release, dut1 blanks it. PS/2 pins change on the falling
// clk edge; outputs are sampled on the falling clk edge.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int CLK_P = 10;
    localparam int TO    = 200;  // shortened timeout for simulation
    localparam int HALF  = 8;    // clk cycles per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key0, key1, sc0, sc1;
    logic       kv0, kv1, sv0, sv1, fe0, fe1;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .RELEASE_BLANK(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key0), .key_valid(kv0), .scan_code(sc0), .scan_valid(sv0),
        .frame_err(fe0)
    );

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .RELEASE_BLANK(1'b1)) dut1 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key1), .key_valid(kv1), .scan_code(sc1), .scan_valid(sv1),
        .frame_err(fe1)
    );

    always #(CLK_P / 2) clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    int  kv0_cnt = 0, kv1_cnt = 0, sv0_cnt = 0, sv1_cnt = 0, fe0_cnt = 0, fe1_cnt = 0;
    int  b_kv0, b_kv1, b_sv0, b_sv1, b_fe0, b_fe1;
    time t_kv0 = 0, t_fe0 = 0, t_fall = 0;

    // Pulse counters and time stamps of the latest pulses.
    always @(negedge clk) begin
        if (kv0) begin kv0_cnt++; t_kv0 = $time; end
        if (kv1) kv1_cnt++;
        if (sv0) sv0_cnt++;
        if (sv1) sv1_cnt++;
        if (fe0) begin fe0_cnt++; t_fe0 = $time; end
        if (fe1) fe1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_kv0 = kv0_cnt; b_kv1 = kv1_cnt;
        b_sv0 = sv0_cnt; b_sv1 = sv1_cnt;
        b_fe0 = fe0_cnt; b_fe1 = fe1_cnt;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        t_fall  = $time;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; bad_par inverts the odd-parity bit.
    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Start bit plus the first nbits-1 data bits, then the clock stops high.
    task automatic send_partial(input logic [7:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits - 1; i++) send_bit(d[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;

        // ---------------- Reset with ps2_clk toggling ----------------
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ps2_clk = ~ps2_clk;
        end
        repeat (3) @(negedge clk);
        check("rst_key0", 32'(key0), 32'h20);
        check("rst_key1", 32'(key1), 32'h20);
        check("rst_scan", 32'(sc0), 32'h00);
        check("rst_pulses", 32'(kv0_cnt + sv0_cnt + fe0_cnt + kv1_cnt + sv1_cnt + fe1_cnt), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // ---------------- First frame 0x45 -> "0" ----------------
        snap();
        send_frame(8'h45, 1'b0);
        check("45_key0", 32'(key0), 32'h30);
        check("45_key1", 32'(key1), 32'h30);
        check("45_scan", 32'(sc0), 32'h45);
        check("45_kv_cnt", 32'(kv0_cnt - b_kv0), 32'd1);
        check("45_sv_cnt", 32'(sv0_cnt - b_sv0), 32'd1);
        // pin fall -> 2 sync stages -> strobe -> CHECK -> key_valid
        lat = int'(t_kv0 - t_fall);
        check("45_kv_latency", 32'(lat), 32'(4 * CLK_P));

        // ---------------- Make / break 16, F0, 16 ----------------
        snap();
        send_frame(8'h16, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        check("mb_key0", 32'(key0), 32'h31);
        check("mb_kv0_cnt", 32'(kv0_cnt - b_kv0), 32'd1);
        check("mb_sv0_cnt", 32'(sv0_cnt - b_sv0), 32'd3);
        check("mb_key1_blank", 32'(key1), 32'h20);
        check("mb_kv1_cnt", 32'(kv1_cnt - b_kv1), 32'd2);
        check("mb_sv1_cnt", 32'(sv1_cnt - b_sv1), 32'd3);
        check("mb_scan", 32'(sc0), 32'h16);

        // ---------------- Parity error, then good 1C ----------------
        snap();
        send_frame(8'h1C, 1'b1);
        check("par_fe_cnt", 32'(fe0_cnt - b_fe0), 32'd1);
        check("par_sv_cnt", 32'(sv0_cnt - b_sv0), 32'd0);
        check("par_kv_cnt", 32'(kv0_cnt - b_kv0), 32'd0);
        check("par_key0", 32'(key0), 32'h31);
        check("par_key1", 32'(key1), 32'h20);
        send_frame(8'h1C, 1'b0);
        check("1C_key0", 32'(key0), 32'h41);
        check("1C_key1", 32'(key1), 32'h41);

        // ---------------- Timeout after 5 bits ----------------
        snap();
        send_partial(8'h29, 5);
        repeat (TO + 20) @(negedge clk);
        check("to_fe_cnt", 32'(fe0_cnt - b_fe0), 32'd1);
        check("to_fe1_cnt", 32'(fe1_cnt - b_fe1), 32'd1);
        lat = int'(t_fe0 - t_fall);
        check("to_latency_window", 32'(lat >= TO * CLK_P && lat <= (TO + 4) * CLK_P), 32'd1);
        check("to_sv_cnt", 32'(sv0_cnt - b_sv0), 32'd0);
        send_frame(8'h29, 1'b0);
        check("29_key0", 32'(key0), 32'h20);
        check("29_kv_cnt", 32'(kv0_cnt - b_kv0), 32'd1);

        // ---------------- Extended E0,75 then unmapped 76 ----------------
        snap();
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h76, 1'b0);
        check("ext_key0", 32'(key0), 32'h20);
        check("ext_kv0_cnt", 32'(kv0_cnt - b_kv0), 32'd0);
        check("ext_kv1_cnt", 32'(kv1_cnt - b_kv1), 32'd0);
        check("ext_scan", 32'(sc0), 32'h76);
        check("ext_sv_cnt", 32'(sv0_cnt - b_sv0), 32'd3);

        // ---------------- Reset mid-frame, then 3E ----------------
        snap();
        send_partial(8'h3E, 6);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_key0", 32'(key0), 32'h20);
        send_frame(8'h3E, 1'b0);
        check("3E_key0", 32'(key0), 32'h38);
        check("3E_key1", 32'(key1), 32'h38);
        check("3E_scan", 32'(sc0), 32'h3E);
        check("mid_rst_fe0", 32'(fe0_cnt - b_fe0), 32'd0);
        check("mid_rst_fe1", 32'(fe1_cnt - b_fe1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
